clint: RTL and testbench

- Core-local interruptor. Sits directly downstream of the cpu top on its memory port; the system decoder routes the CLINT window to it.
- Consumes memory_valid/instr/addr/wdata/wstrb requests from the cpu.
- Produces memory_rdata/ready/error responses, plus the mtime, mtip and msip inputs that the cpu's csr unit consumes.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip software-interrupt bit.

---
 rtl/clint.sv | 151 +++++++++++++++
 tb/tb_clint.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer, msip bit, single-beat register port.
// Define CLINT_MTIME_WRITE_EN to make mtime writable; by default mtime is read-only.
module clint #(
   parameter logic [31:0] clint_base     = 32'h0200_0000,
   parameter int unsigned clint_prescale = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memory_valid,
   input  logic        memory_instr,
   input  logic [31:0] memory_addr,
   input  logic [31:0] memory_wdata,
   input  logic [3:0]  memory_wstrb,
   output logic [31:0] memory_rdata,
   output logic        memory_error,
   output logic        memory_ready,
   output logic        mtip,
   output logic        msip,
   output logic [63:0] mtime
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

`ifdef CLINT_MTIME_WRITE_EN
   localparam bit mtime_writable = 1'b1;
`else
   localparam bit mtime_writable = 1'b0;
`endif

   localparam logic [15:0] presc_last = 16'(clint_prescale - 1);

   state_t      state, state_next;
   logic [15:0] presc;
   logic        tick;
   logic [63:0] mtimecmp;
   logic [63:0] mtime_next;
   logic [15:0] offset;
   logic        access;
   logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
   logic        is_write, access_error;
   logic [31:0] read_data;
   logic        we_msip, we_cmp_lo, we_cmp_hi, we_time_lo, we_time_hi;
   logic        unused;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++)
         if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      return merged;
   endfunction

   // The window is 64 KiB aligned, so only the low half of the address is decoded.
   assign offset = memory_addr[15:0] - clint_base[15:0];
   assign unused = &{1'b0, memory_addr[31:16]};
   assign tick   = (presc == presc_last);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next   = state;
      access       = 1'b0;
      memory_ready = 1'b0;
      case (state)
         IDLE: begin
            if (memory_valid) begin
               access     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            // A still-asserted valid here is the request being answered, not a new one.
            memory_ready = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sel_msip    = (offset == 16'h0000);
      sel_cmp_lo  = (offset == 16'h4000);
      sel_cmp_hi  = (offset == 16'h4004);
      sel_time_lo = (offset == 16'hBFF8);
      sel_time_hi = (offset == 16'hBFFC);
      is_write    = |memory_wstrb;

      access_error = memory_instr
                   | (memory_addr[1:0] != 2'b00)
                   | !(sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi)
                   | (!mtime_writable & is_write & (sel_time_lo | sel_time_hi));

      read_data = '0;
      if (!access_error) begin
         if (sel_msip)    read_data = {31'd0, msip};
         if (sel_cmp_lo)  read_data = mtimecmp[31:0];
         if (sel_cmp_hi)  read_data = mtimecmp[63:32];
         if (sel_time_lo) read_data = mtime[31:0];
         if (sel_time_hi) read_data = mtime[63:32];
      end

      we_msip    = access & !access_error & is_write & sel_msip & memory_wstrb[0];
      we_cmp_lo  = access & !access_error & is_write & sel_cmp_lo;
      we_cmp_hi  = access & !access_error & is_write & sel_cmp_hi;
      we_time_lo = access & !access_error & is_write & sel_time_lo;
      we_time_hi = access & !access_error & is_write & sel_time_hi;

      // A software write to either mtime word wins over the tick for the whole register.
      mtime_next = mtime;
      if (we_time_lo | we_time_hi) begin
         if (we_time_lo) mtime_next[31:0]  = merge_bytes(mtime[31:0],  memory_wdata, memory_wstrb);
         if (we_time_hi) mtime_next[63:32] = merge_bytes(mtime[63:32], memory_wdata, memory_wstrb);
      end else if (tick) begin
         mtime_next = mtime + 64'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc        <= '0;
         mtime        <= '0;
         mtimecmp     <= '1;
         msip         <= 1'b0;
         mtip         <= 1'b0;
         memory_rdata <= '0;
         memory_error <= 1'b0;
      end else begin
         presc <= tick ? 16'd0 : presc + 16'd1;
         mtime <= mtime_next;
         if (we_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  memory_wdata, memory_wstrb);
         if (we_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], memory_wdata, memory_wstrb);
         if (we_msip)   msip <= memory_wdata[0];
         mtip <= (mtime >= mtimecmp);
         if (access) begin
            memory_rdata <= read_data;
            memory_error <= access_error;
         end
      end
   end

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint with clint_prescale=4.
// Covers both builds: expectations for mtime writes follow CLINT_MTIME_WRITE_EN.
module tb_clint;

   localparam logic [31:0] base = 32'h0200_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        memory_valid, memory_instr;
   logic [31:0] memory_addr, memory_wdata;
   logic [3:0]  memory_wstrb;
   logic [31:0] memory_rdata;
   logic        memory_error, memory_ready;
   logic        mtip, msip;
   logic [63:0] mtime;

   int unsigned cyc;
   int          passed = 0;
   int          total = 0;
   logic        mtip_at_ready;
   logic [31:0] rd;
   logic        er;
   logic [63:0] exp_time;

   clint #(.clint_base(base), .clint_prescale(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .memory_valid (memory_valid),
      .memory_instr (memory_instr),
      .memory_addr  (memory_addr),
      .memory_wdata (memory_wdata),
      .memory_wstrb (memory_wstrb),
      .memory_rdata (memory_rdata),
      .memory_error (memory_error),
      .memory_ready (memory_ready),
      .mtip         (mtip),
      .msip         (msip),
      .mtime        (mtime)
   );

   always #5 clock = ~clock;

   // Clock edges since reset release; with prescale 4, mtime ticks whenever this hits a multiple of 4.
   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic bus(input logic [15:0] off, input logic [31:0] wd, input logic [3:0] ws,
                      input logic ins, output logic [31:0] rdata, output logic err);
      int lat = 0;
      memory_valid = 1'b1;
      memory_addr  = base | {16'h0, off};
      memory_wdata = wd;
      memory_wstrb = ws;
      memory_instr = ins;
      do begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end while (!memory_ready && lat < 8);
      check("latency", 64'(lat), 64'd1);
      rdata         = memory_rdata;
      err           = memory_error;
      mtip_at_ready = mtip;
      memory_valid  = 1'b0;
      memory_wstrb  = 4'h0;
      memory_instr  = 1'b0;
      memory_wdata  = '0;
      @(posedge clock);
      #1;
      check("ready_one_cycle", memory_ready, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int pulses;
      memory_valid = 1'b0;
      memory_instr = 1'b0;
      memory_addr  = '0;
      memory_wdata = '0;
      memory_wstrb = 4'h0;

      // Reset state and a first read.
      do_reset();
      check("rst_mtime", mtime, 64'd0);
      check("rst_mtip", mtip, 1'b0);
      check("rst_msip", msip, 1'b0);
      check("rst_ready", memory_ready, 1'b0);
      check("rst_error", memory_error, 1'b0);
      check("rst_rdata", memory_rdata, 32'h0);
      bus(16'h4004, 32'h0, 4'h0, 1'b0, rd, er);
      check("cmp_hi_rst", rd, 32'hFFFF_FFFF);
      check("cmp_hi_err", er, 1'b0);
      bus(16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
      check("cmp_lo_rst", rd, 32'hFFFF_FFFF);

      // Prescaled counting.
      exp_time = 64'(cyc / 4);
      bus(16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
      check("mtime_lo_read", rd, exp_time[31:0]);
      check("mtime_lo_err", er, 1'b0);
      while (cyc < 40) begin @(posedge clock); #1; end
      check("mtime_40cyc", mtime, 64'd10);
      repeat (8) begin
         @(posedge clock); #1;
         check("mtime_step", mtime, 64'(cyc / 4));
      end

      // Timer compare and mtip timing.
      do_reset();
      bus(16'h4004, 32'h0, 4'hF, 1'b0, rd, er);
      check("cmp_hi_wr_err", er, 1'b0);
      bus(16'h4000, 32'd5, 4'hF, 1'b0, rd, er);
      n = 0;
      while (mtime != 64'd5 && n < 40) begin @(posedge clock); #1; n++; end
      check("mtime_reach5", mtime, 64'd5);
      check("mtip_before", mtip, 1'b0);
      @(posedge clock); #1;
      check("mtip_rise", mtip, 1'b1);
      bus(16'h4000, 32'd100, 4'hF, 1'b0, rd, er);
      check("mtip_at_ready", mtip_at_ready, 1'b1);
      check("mtip_fall", mtip, 1'b0);
      bus(16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
      check("cmp_lo_rd", rd, 32'd100);
      bus(16'h4004, 32'hAABB_CCDD, 4'b0100, 1'b0, rd, er);
      bus(16'h4004, 32'h0, 4'h0, 1'b0, rd, er);
      check("cmp_hi_partial", rd, 32'h00BB_0000);
      check("mtip_low", mtip, 1'b0);

      // Software interrupt bit.
      bus(16'h0000, 32'h3, 4'b0001, 1'b0, rd, er);
      check("msip_set", msip, 1'b1);
      check("msip_set_err", er, 1'b0);
      bus(16'h0000, 32'h0, 4'h0, 1'b0, rd, er);
      check("msip_rd", rd, 32'h1);
      bus(16'h0000, 32'h0, 4'b0010, 1'b0, rd, er);
      check("msip_b1_only", msip, 1'b1);
      bus(16'h0000, 32'hFFFF_FFFE, 4'hF, 1'b0, rd, er);
      check("msip_clear", msip, 1'b0);
      bus(16'h0000, 32'h1, 4'hF, 1'b0, rd, er);
      check("msip_reset", msip, 1'b1);

      // Access faults leave state untouched.
      bus(16'h0008, 32'h0, 4'h0, 1'b0, rd, er);
      check("unmapped_err", er, 1'b1);
      check("unmapped_rd", rd, 32'h0);
      bus(16'h0000, 32'h0, 4'h0, 1'b1, rd, er);
      check("fetch_err", er, 1'b1);
      check("fetch_rd", rd, 32'h0);
      bus(16'h0000, 32'h0, 4'hF, 1'b1, rd, er);
      check("fetch_wr_err", er, 1'b1);
      check("fetch_wr_msip", msip, 1'b1);
      bus(16'h4001, 32'h0, 4'hF, 1'b0, rd, er);
      check("misalign_err", er, 1'b1);
      bus(16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
      check("misalign_nochg", rd, 32'd100);
      bus(16'h0004, 32'h1, 4'hF, 1'b0, rd, er);
      check("unmapped_wr_err", er, 1'b1);

      // Held valid: one completion every two cycles.
      memory_valid = 1'b1;
      memory_addr  = base | 32'h4000;
      memory_wstrb = 4'h0;
      pulses = 0;
      repeat (6) begin
         @(posedge clock); @(negedge clock);
         if (memory_ready) pulses++;
      end
      memory_valid = 1'b0;
      @(posedge clock); #1;
      check("b2b_pulses", 64'(pulses), 64'd3);
      check("b2b_rdata", memory_rdata, 32'd100);

      // mtime writes.
`ifdef CLINT_MTIME_WRITE_EN
      bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
      check("mtime_hi_wr_err", er, 1'b0);
      while (cyc % 4 != 3) begin @(posedge clock); #1; end
      bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
      check("mtime_lo_wr_err", er, 1'b0);
      check("mtime_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
      repeat (2) begin @(posedge clock); #1; end
      check("mtime_ones_hold", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clock); #1;
      check("mtime_wrap", mtime, 64'd0);
      repeat (4) begin @(posedge clock); #1; end
      check("mtime_after_wrap", mtime, 64'd1);
`else
      bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
      check("mtime_lo_ro_err", er, 1'b1);
      check("mtime_lo_ro_rd", rd, 32'h0);
      bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
      check("mtime_hi_ro_err", er, 1'b1);
      check("mtime_ro_count", mtime, 64'(cyc / 4));
      exp_time = 64'(cyc / 4);
      bus(16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
      check("mtime_ro_read", rd, exp_time[31:0]);
      check("mtime_ro_read_err", er, 1'b0);
`endif

      // Reset while a request is pending drops it.
      memory_valid = 1'b1;
      memory_addr  = base | 32'h4004;
      reset        = 1'b1;
      @(posedge clock); #1;
      reset        = 1'b0;
      memory_valid = 1'b0;
      check("rst_mid_ready", memory_ready, 1'b0);
      @(negedge clock);
      check("rst_mid_ready2", memory_ready, 1'b0);
      @(posedge clock); #1;
      check("rst_mid_msip", msip, 1'b0);
      check("rst_mid_mtime", mtime, 64'd0);
      bus(16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
      check("rst_mid_cmp", rd, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
